// File: rtl/md5_pkg.sv
// Shared MD5 types, constants and the single-step round function.
package md5_pkg;

  typedef logic [31:0]   word_t;
  typedef logic [127:0]  digest_t;
  typedef word_t [15:0]  block_t;

  localparam word_t IV_A = 32'h67452301;
  localparam word_t IV_B = 32'hefcdab89;
  localparam word_t IV_C = 32'h98badcfe;
  localparam word_t IV_D = 32'h10325476;

  localparam word_t K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S_TAB [64] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  // Message word used by step i.
  function automatic logic [3:0] msg_index(input logic [5:0] i);
    case (i[5:4])
      2'd0:    return i[3:0];
      2'd1:    return 4'(i[3:0] * 4'd5 + 4'd1);
      2'd2:    return 4'(i[3:0] * 4'd3 + 4'd5);
      default: return 4'(i[3:0] * 4'd7);
    endcase
  endfunction

  // One MD5 step; returns the new B (A, C, D simply rotate).
  function automatic word_t md5_step(input word_t a, input word_t b, input word_t c,
                                     input word_t d, input word_t m, input logic [5:0] i);
    word_t f;
    word_t t;
    case (i[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    t = a + f + K_TAB[i] + m;
    return b + ((t << S_TAB[i]) | (t >> (6'd32 - {1'b0, S_TAB[i]})));
  endfunction

  // Little-endian word to big-endian byte order.
  function automatic word_t bswap(input word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/md5_padder.sv
// Combinational MD5 single-block padding of a short message.
module md5_padder
  import md5_pkg::*;
#(
  parameter int unsigned MAX_MSG_LENGTH = 56
) (
  input  logic [8*MAX_MSG_LENGTH-1:0] msg_data,
  input  logic [5:0]                  msg_length,
  output block_t                      block,
  output logic                        length_error
);

  logic [7:0] pad_bytes [64];

  // Data bytes, 0x80 terminator, zero fill, then bit length in bytes 56..63.
  always_comb begin
    for (int b = 0; b < 64; b++) pad_bytes[b] = 8'h00;
    for (int b = 0; b < 56; b++) begin
      if (6'(b) < msg_length) pad_bytes[b] = msg_data[8*b +: 8];
    end
    for (int b = 0; b < 56; b++) begin
      if (6'(b) == msg_length) pad_bytes[b] = 8'h80;
    end
    pad_bytes[56] = {msg_length[4:0], 3'b000};
    pad_bytes[57] = {7'b0000000, msg_length[5]};
    for (int j = 0; j < 16; j++) begin
      block[j] = {pad_bytes[4*j+3], pad_bytes[4*j+2], pad_bytes[4*j+1], pad_bytes[4*j]};
    end
  end

  assign length_error = (msg_length > 6'd55);

endmodule

// File: rtl/md5_block_hasher.sv
// Iterative single-block MD5 hasher with leading-zero-nibble hit flag.
// Optional MD5_TWO_STEPS_PER_CYCLE_EN: two MD5 steps per ROUND cycle.
module md5_block_hasher
  import md5_pkg::*;
#(
  parameter int unsigned MAX_MSG_LENGTH = 56,
  parameter int unsigned ZERO_NIBBLES   = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        msg_valid,
  output logic                        msg_ready,
  input  logic [5:0]                  msg_length,
  input  logic [8*MAX_MSG_LENGTH-1:0] msg_data,
  output logic                        digest_valid,
  input  logic                        digest_ready,
  output digest_t                     digest,
  output logic                        digest_hit,
  output logic                        length_error
);

  localparam int unsigned HIT_BITS = ZERO_NIBBLES * 4;
`ifdef MD5_TWO_STEPS_PER_CYCLE_EN
  localparam logic [5:0] LAST_STEP = 6'd62;
  localparam logic [5:0] STEP_INC  = 6'd2;
`else
  localparam logic [5:0] LAST_STEP = 6'd63;
  localparam logic [5:0] STEP_INC  = 6'd1;
`endif

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t     state, state_nxt;
  block_t     blk, blk_nxt;
  word_t      a, b, c, d;
  word_t      a_nxt, b_nxt, c_nxt, d_nxt;
  logic [5:0] step, step_nxt;
  digest_t    digest_nxt, fin_digest;
  logic       hit_nxt, err_nxt, valid_nxt, ready_nxt;
  block_t     pad_block;
  logic       pad_err;
  word_t      b1;
`ifdef MD5_TWO_STEPS_PER_CYCLE_EN
  word_t      b2;
`endif

  md5_padder #(.MAX_MSG_LENGTH(MAX_MSG_LENGTH)) u_padder (
    .msg_data     (msg_data),
    .msg_length   (msg_length),
    .block        (pad_block),
    .length_error (pad_err)
  );

  // Round datapath and final digest assembly.
  always_comb begin
    b1 = md5_step(a, b, c, d, blk[msg_index(step)], step);
`ifdef MD5_TWO_STEPS_PER_CYCLE_EN
    b2 = md5_step(d, b1, b, c, blk[msg_index(6'(step + 6'd1))], 6'(step + 6'd1));
`endif
    fin_digest = {bswap(a + IV_A), bswap(b + IV_B), bswap(c + IV_C), bswap(d + IV_D)};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt  = state;
    blk_nxt    = blk;
    a_nxt      = a;
    b_nxt      = b;
    c_nxt      = c;
    d_nxt      = d;
    step_nxt   = step;
    digest_nxt = digest;
    hit_nxt    = digest_hit;
    err_nxt    = length_error;
    case (state)
      IDLE: begin
        if (msg_valid && msg_ready) begin
          blk_nxt  = pad_block;
          a_nxt    = IV_A;
          b_nxt    = IV_B;
          c_nxt    = IV_C;
          d_nxt    = IV_D;
          step_nxt = '0;
          err_nxt  = pad_err;
          if (pad_err) begin
            digest_nxt = '0;
            hit_nxt    = 1'b0;
            state_nxt  = DONE;
          end else begin
            state_nxt  = ROUND;
          end
        end
      end
      ROUND: begin
`ifdef MD5_TWO_STEPS_PER_CYCLE_EN
        a_nxt = c;
        b_nxt = b2;
        c_nxt = b1;
        d_nxt = b;
`else
        a_nxt = d;
        b_nxt = b1;
        c_nxt = b;
        d_nxt = c;
`endif
        step_nxt = 6'(step + STEP_INC);
        if (step == LAST_STEP) state_nxt = FINAL;
      end
      FINAL: begin
        digest_nxt = fin_digest;
        hit_nxt    = (fin_digest[127 -: HIT_BITS] == '0);
        state_nxt  = DONE;
      end
      DONE: begin
        if (digest_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    valid_nxt = (state_nxt == DONE);
    ready_nxt = (state_nxt == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      blk          <= '0;
      a            <= '0;
      b            <= '0;
      c            <= '0;
      d            <= '0;
      step         <= '0;
      digest       <= '0;
      digest_hit   <= 1'b0;
      length_error <= 1'b0;
      digest_valid <= 1'b0;
      msg_ready    <= 1'b1;
    end else begin
      state        <= state_nxt;
      blk          <= blk_nxt;
      a            <= a_nxt;
      b            <= b_nxt;
      c            <= c_nxt;
      d            <= d_nxt;
      step         <= step_nxt;
      digest       <= digest_nxt;
      digest_hit   <= hit_nxt;
      length_error <= err_nxt;
      digest_valid <= valid_nxt;
      msg_ready    <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_md5_block_hasher.sv
// Directed self-checking bench for md5_block_hasher against a behavioural MD5 model.
module tb_md5_block_hasher;

`ifdef MD5_TWO_STEPS_PER_CYCLE_EN
  localparam int EXP_LAT = 34;
`else
  localparam int EXP_LAT = 66;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         msg_valid;
  logic         msg_ready;
  logic [5:0]   msg_length;
  logic [447:0] msg_data;
  logic         digest_valid;
  logic         digest_ready;
  logic [127:0] digest;
  logic         digest_hit;
  logic         length_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] exp_digest = '0;
  logic         exp_hit    = 1'b0;
  logic         exp_err    = 1'b0;
  logic [31:0]  kk [64];

  md5_block_hasher dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg_length   (msg_length),
    .msg_data     (msg_data),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .digest       (digest),
    .digest_hit   (digest_hit),
    .length_error (length_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bsw(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Textbook MD5 of a message of up to 55 bytes; 0 for longer lengths.
  function automatic logic [127:0] model_md5(input logic [7:0] m [64], input int len);
    logic [7:0]  blk [64];
    logic [31:0] w [16];
    logic [31:0] a0, b0, c0, d0, f, tmp, sum;
    logic [63:0] bitlen;
    int          g, sh;
    int          sh_tab [4][4];
    sh_tab = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    if (len > 55) return '0;
    for (int i = 0; i < 64; i++) blk[i] = (i < len) ? m[i] : 8'h00;
    blk[len] = 8'h80;
    bitlen = 64'(len) * 64'd8;
    for (int k = 0; k < 8; k++) blk[56+k] = bitlen[8*k +: 8];
    for (int j = 0; j < 16; j++) w[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
    a0 = 32'h67452301; b0 = 32'hefcdab89; c0 = 32'h98badcfe; d0 = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b0 & c0) | (~b0 & d0); g = i;              end
        1:       begin f = (d0 & b0) | (~d0 & c0); g = (5 * i + 1) % 16; end
        2:       begin f = b0 ^ c0 ^ d0;           g = (3 * i + 5) % 16; end
        default: begin f = c0 ^ (b0 | ~d0);        g = (7 * i) % 16;     end
      endcase
      sh  = sh_tab[i / 16][i % 4];
      sum = a0 + f + kk[i] + w[g];
      tmp = d0;
      d0  = c0;
      c0  = b0;
      b0  = b0 + ((sum << sh) | (sum >> (32 - sh)));
      a0  = tmp;
    end
    return {bsw(a0 + 32'h67452301), bsw(b0 + 32'hefcdab89),
            bsw(c0 + 32'h98badcfe), bsw(d0 + 32'h10325476)};
  endfunction

  // Present a message once msg_ready is seen; returns just after the acceptance edge.
  task automatic send(input string s, input int len);
    logic [7:0] mb [64];
    int guard = 0;
    while (!msg_ready && guard < 200) begin @(negedge clk); guard++; end
    check("ready_before_send", 128'(msg_ready), 128'(1));
    for (int i = 0; i < 64; i++) mb[i] = (i < s.len()) ? s[i] : 8'h00;
    for (int i = 0; i < 56; i++) msg_data[8*i +: 8] = mb[i];
    exp_digest = model_md5(mb, len);
    exp_hit    = (exp_digest[127:108] == 20'd0) && (len <= 55);
    exp_err    = (len > 55);
    msg_length = 6'(len);
    msg_valid  = 1'b1;
    @(posedge clk);
    #1 msg_valid = 1'b0;
  endtask

  // Count cycles to digest_valid and pin the result against a literal.
  task automatic wait_result(input int exp_lat, input logic [127:0] lit, input logic lit_hit,
                             input logic lit_err);
    int lat = 1;
    while (!digest_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    check("latency", 128'(lat), 128'(exp_lat));
    check("digest_lit", digest, lit);
    check("hit_lit", 128'(digest_hit), 128'(lit_hit));
    check("err_lit", 128'(length_error), 128'(lit_err));
  endtask

  // One-cycle digest_ready pulse, then confirm the block is idle again.
  task automatic consume();
    @(negedge clk);
    digest_ready = 1'b1;
    @(posedge clk);
    #1 digest_ready = 1'b0;
    check("valid_drop", 128'(digest_valid), 128'(0));
    check("ready_back", 128'(msg_ready), 128'(1));
    @(negedge clk);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (digest_valid) seen = 1'b1;
    end
    check(name, 128'(seen), 128'(0));
  endtask

  // Compare process: model result on every cycle the digest is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && digest_valid === 1'b1) begin
        check("mdl_digest", digest, exp_digest);
        check("mdl_hit", 128'(digest_hit), 128'(exp_hit));
        check("mdl_err", 128'(length_error), 128'(exp_err));
        check("mdl_ready_low", 128'(msg_ready), 128'(0));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      real r;
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kk[i] = 32'(longint'($floor(4294967296.0 * r)));
    end
    reset_n      = 1'b0;
    msg_valid    = 1'b0;
    msg_length   = '0;
    msg_data     = '0;
    digest_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(msg_ready), 128'(1));
    check("rst_valid", 128'(digest_valid), 128'(0));
    check("rst_digest", digest, 128'(0));
    check("rst_hit", 128'(digest_hit), 128'(0));
    check("rst_err", 128'(length_error), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    send("", 0);
    wait_result(EXP_LAT, 128'hd41d8cd98f00b204e9800998ecf8427e, 1'b0, 1'b0);
    consume();

    send("abc", 3);
    wait_result(EXP_LAT, 128'h900150983cd24fb0d6963f7d28e17f72, 1'b0, 1'b0);
    consume();

    send("abcdef609043", 12);
    wait_result(EXP_LAT, 128'h000001dbbfa3a5c83a2d506429c7b00e, 1'b1, 1'b0);
    consume();

    send("The quick brown fox jumps over the lazy dog", 43);
    wait_result(EXP_LAT, 128'h9e107d9d372bb6826bd81d3542a419d6, 1'b0, 1'b0);
    @(negedge clk);
    msg_valid  = 1'b1;
    msg_length = 6'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_ready_low", 128'(msg_ready), 128'(0));
      check("hold_digest", digest, 128'h9e107d9d372bb6826bd81d3542a419d6);
    end
    msg_valid = 1'b0;
    consume();
    expect_quiet("no_accept_while_done", 80);

    send("abc", 56);
    wait_result(1, 128'(0), 1'b0, 1'b1);
    consume();
    send("abc", 3);
    wait_result(EXP_LAT, 128'h900150983cd24fb0d6963f7d28e17f72, 1'b0, 1'b0);
    consume();

    send("abc", 3);
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", 128'(digest_valid), 128'(0));
    check("midrst_ready", 128'(msg_ready), 128'(1));
    check("midrst_digest", digest, 128'(0));
    check("midrst_hit", 128'(digest_hit), 128'(0));
    check("midrst_err", 128'(length_error), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    expect_quiet("no_valid_after_reset", 80);
    send("abc", 3);
    wait_result(EXP_LAT, 128'h900150983cd24fb0d6963f7d28e17f72, 1'b0, 1'b0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
